mem_bus_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 49 ++++
 rtl/mem_bus_arbiter_rr_pick5.sv | 38 +++
 rtl/mem_bus_arbiter.sv | 238 +++++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the QSPI memory-port arbiter: source indices, FSM encoding,
// request payload layout and the watchdog default.
package mem_arb_pkg;

    localparam int unsigned NSRC   = 5;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned ADR_W  = 32;
    localparam int unsigned DATA_W = 32;

    localparam int unsigned SRC_DW = 0;
    localparam int unsigned SRC_DR = 1;
    localparam int unsigned SRC_IR = 2;
    localparam int unsigned SRC_UW = 3;
    localparam int unsigned SRC_UR = 4;

    localparam int unsigned TIMEOUT_CYC = 4096;
    localparam int unsigned TMO_W       = 13;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2,
        ST_WAIT_WR = 2'd3
    } arb_state_e;

    // Latched request as captured from a source; read sources carry zero data.
    typedef struct packed {
        logic              w;
        logic              hw;
        logic [ADR_W-1:0]  adr;
        logic [DATA_W-1:0] data;
    } mem_req_t;

    typedef struct packed {
        logic             w;
        logic             hw;
        logic [ADR_W-1:0] adr;
    } rd_cmd_t;

    function automatic logic is_write_src(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(SRC_DW)) || (idx == IDX_W'(SRC_UW));
    endfunction

    // Round-robin pointer update: one past the grant, wrapping at NSRC.
    function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] g);
        return (g >= IDX_W'(NSRC - 1)) ? '0 : g + IDX_W'(1);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick5.sv
// rr_pick5: combinational circular first-one finder over the five pending flags,
// starting the search at the round-robin pointer.
module rr_pick5
    import mem_arb_pkg::*;
(
    input  logic [NSRC-1:0]  pend,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant_idx_c,
    output logic             grant_vld_c
);

    localparam int unsigned SUM_W = IDX_W + 1;

    logic [IDX_W-1:0] base_c;
    logic [SUM_W-1:0] sum_c;
    logic [IDX_W-1:0] idx_c;

    always_comb begin
        grant_idx_c = '0;
        grant_vld_c = 1'b0;
        sum_c       = '0;
        idx_c       = '0;
        // An out-of-range pointer cannot occur, but is folded to 0 for safety.
        base_c      = (ptr < IDX_W'(NSRC)) ? ptr : '0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            sum_c = SUM_W'(base_c) + SUM_W'(k);
            if (sum_c >= SUM_W'(NSRC)) begin
                sum_c = sum_c - SUM_W'(NSRC);
            end
            idx_c = IDX_W'(sum_c);
            if (!grant_vld_c && pend[idx_c]) begin
                grant_vld_c = 1'b1;
                grant_idx_c = idx_c;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin sequencer putting five request sources onto one QSPI port.
// Define MEM_ARB_TIMEOUT_EN to add the wait-state watchdog and the sticky arb_timeout output.
module mem_bus_arbiter
    import mem_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_read_req,
    input  logic        i_read_w,
    input  logic        i_read_hw,
    input  logic [31:0] i_read_adr,
    input  logic        d_read_req,
    input  logic        d_read_w,
    input  logic        d_read_hw,
    input  logic [31:0] d_read_adr,
    input  logic        u_read_req,
    input  logic        u_read_w,
    input  logic [31:0] u_read_adr,

    input  logic        d_write_req,
    input  logic        d_write_w,
    input  logic        d_write_hw,
    input  logic [31:0] d_write_adr,
    input  logic [31:0] d_write_data,
    input  logic        u_write_req,
    input  logic        u_write_w,
    input  logic [31:0] u_write_adr,
    input  logic [31:0] u_write_data,

    output logic        read_req,
    output logic        read_w,
    output logic        read_hw,
    output logic [31:0] read_adr,
    output logic        write_req,
    output logic        write_w,
    output logic        write_hw,
    output logic [31:0] write_adr,
    output logic [31:0] write_data,
    input  logic        read_valid,
    input  logic        write_finish,

    output logic        i_read_valid,
    output logic        d_read_valid,
    output logic        u_read_valid,
    output logic        d_write_finish,
    output logic        u_write_finish,
    output logic        arb_busy,
    output logic        req_overrun
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    output logic        arb_timeout
`endif
);

    arb_state_e       state_q, state_d;
    logic [NSRC-1:0]  req_vec, pend_q, pend_d, clr_vec, take_vec;
    mem_req_t         in_req [NSRC];
    mem_req_t         slot_q [NSRC];
    mem_req_t         slot_d [NSRC];
    logic [IDX_W-1:0] ptr_q, ptr_d, grant_q, grant_d;
    logic [IDX_W-1:0] pick_idx_c;
    logic             pick_vld_c;
    rd_cmd_t          rd_q, rd_d;
    mem_req_t         wr_q, wr_d;
    logic             read_req_q, read_req_d, write_req_q, write_req_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;
    logic             rd_done_c, wr_done_c, tmo_hit_c;

    // Gather the five request ports into index-ordered vectors.
    always_comb begin
        req_vec         = '0;
        req_vec[SRC_DW] = d_write_req;
        req_vec[SRC_DR] = d_read_req;
        req_vec[SRC_IR] = i_read_req;
        req_vec[SRC_UW] = u_write_req;
        req_vec[SRC_UR] = u_read_req;
        in_req[SRC_DW]  = '{w: d_write_w, hw: d_write_hw, adr: d_write_adr, data: d_write_data};
        in_req[SRC_DR]  = '{w: d_read_w,  hw: d_read_hw,  adr: d_read_adr,  data: '0};
        in_req[SRC_IR]  = '{w: i_read_w,  hw: i_read_hw,  adr: i_read_adr,  data: '0};
        in_req[SRC_UW]  = '{w: u_write_w, hw: 1'b0,       adr: u_write_adr, data: u_write_data};
        in_req[SRC_UR]  = '{w: u_read_w,  hw: 1'b0,       adr: u_read_adr,  data: '0};
    end

    // Capture: a new pulse beats the owner's completion clear; a pulse on a still-pending source is dropped.
    always_comb begin
        pend_d    = (pend_q & ~clr_vec) | req_vec;
        take_vec  = req_vec & (~pend_q | clr_vec);
        overrun_d = overrun_q | (|(req_vec & pend_q & ~clr_vec));
        for (int unsigned k = 0; k < NSRC; k++) begin
            slot_d[k] = take_vec[k] ? in_req[k] : slot_q[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q    <= '0;
            overrun_q <= 1'b0;
            for (int unsigned k = 0; k < NSRC; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
            for (int unsigned k = 0; k < NSRC; k++) begin
                slot_q[k] <= slot_d[k];
            end
        end
    end

    rr_pick5 u_pick (
        .pend        (pend_q),
        .ptr         (ptr_q),
        .grant_idx_c (pick_idx_c),
        .grant_vld_c (pick_vld_c)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (pick_vld_c) state_d = ST_ISSUE;
            ST_ISSUE:   state_d = is_write_src(grant_q) ? ST_WAIT_WR : ST_WAIT_RD;
            ST_WAIT_RD: if (read_valid || tmo_hit_c) state_d = ST_IDLE;
            ST_WAIT_WR: if (write_finish || tmo_hit_c) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: memory command loaded on grant, completion routing and pointer advance.
    always_comb begin
        read_req_d  = 1'b0;
        write_req_d = 1'b0;
        rd_d        = rd_q;
        wr_d        = wr_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        clr_vec     = '0;
        busy_d      = (state_d != ST_IDLE);
        rd_done_c   = (state_q == ST_WAIT_RD) && (read_valid || tmo_hit_c);
        wr_done_c   = (state_q == ST_WAIT_WR) && (write_finish || tmo_hit_c);
        if ((state_q == ST_IDLE) && pick_vld_c) begin
            grant_d = pick_idx_c;
            if (is_write_src(pick_idx_c)) begin
                write_req_d = 1'b1;
                wr_d        = slot_q[pick_idx_c];
            end else begin
                read_req_d  = 1'b1;
                rd_d.w      = slot_q[pick_idx_c].w;
                rd_d.hw     = slot_q[pick_idx_c].hw;
                rd_d.adr    = slot_q[pick_idx_c].adr;
            end
        end
        if (rd_done_c || wr_done_c) begin
            clr_vec[grant_q] = 1'b1;
            ptr_d            = ptr_after(grant_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_req_q  <= 1'b0;
            write_req_q <= 1'b0;
            rd_q        <= '0;
            wr_q        <= '0;
            grant_q     <= '0;
            ptr_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            read_req_q  <= read_req_d;
            write_req_q <= write_req_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            busy_q      <= busy_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_flag_q, tmo_flag_d;
    logic             in_wait_c;

    // Watchdog: forces the owner's completion when memory never answers.
    always_comb begin
        in_wait_c  = (state_q == ST_WAIT_RD) || (state_q == ST_WAIT_WR);
        tmo_cnt_d  = in_wait_c ? tmo_cnt_q + TMO_W'(1) : '0;
        tmo_hit_c  = in_wait_c && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1))
                     && !((state_q == ST_WAIT_RD) ? read_valid : write_finish);
        tmo_flag_d = tmo_flag_q | tmo_hit_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q  <= '0;
            tmo_flag_q <= 1'b0;
        end else begin
            tmo_cnt_q  <= tmo_cnt_d;
            tmo_flag_q <= tmo_flag_d;
        end
    end

    assign arb_timeout = tmo_flag_q;
`else
    assign tmo_hit_c = 1'b0;
`endif

    assign read_req       = read_req_q;
    assign read_w         = rd_q.w;
    assign read_hw        = rd_q.hw;
    assign read_adr       = rd_q.adr;
    assign write_req      = write_req_q;
    assign write_w        = wr_q.w;
    assign write_hw       = wr_q.hw;
    assign write_adr      = wr_q.adr;
    assign write_data     = wr_q.data;
    assign arb_busy       = busy_q;
    assign req_overrun    = overrun_q;

    // Completion pulses follow read_valid/write_finish in the same cycle, owner only.
    assign d_write_finish = wr_done_c && (grant_q == IDX_W'(SRC_DW));
    assign u_write_finish = wr_done_c && (grant_q == IDX_W'(SRC_UW));
    assign d_read_valid   = rd_done_c && (grant_q == IDX_W'(SRC_DR));
    assign i_read_valid   = rd_done_c && (grant_q == IDX_W'(SRC_IR));
    assign u_read_valid   = rd_done_c && (grant_q == IDX_W'(SRC_UR));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: expected memory commands are queued as
// requests are driven and popped as the arbiter issues them to the memory port.
module tb_mem_bus_arbiter;

    logic        clk, rst_n;
    logic        i_read_req, i_read_w, i_read_hw;
    logic [31:0] i_read_adr;
    logic        d_read_req, d_read_w, d_read_hw;
    logic [31:0] d_read_adr;
    logic        u_read_req, u_read_w;
    logic [31:0] u_read_adr;
    logic        d_write_req, d_write_w, d_write_hw;
    logic [31:0] d_write_adr, d_write_data;
    logic        u_write_req, u_write_w;
    logic [31:0] u_write_adr, u_write_data;
    logic        read_req, read_w, read_hw;
    logic [31:0] read_adr;
    logic        write_req, write_w, write_hw;
    logic [31:0] write_adr, write_data;
    logic        read_valid, write_finish;
    logic        i_read_valid, d_read_valid, u_read_valid;
    logic        d_write_finish, u_write_finish;
    logic        arb_busy, req_overrun;
`ifdef MEM_ARB_TIMEOUT_EN
    logic        arb_timeout;
`endif

    typedef struct packed {
        logic        is_wr;
        logic [2:0]  src;
        logic        w;
        logic        hw;
        logic [31:0] adr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc_n  = 0;
    logic [4:0]  done_v;
    logic [141:0] all_out;

    assign done_v  = {u_read_valid, u_write_finish, i_read_valid, d_read_valid, d_write_finish};
    assign all_out = {read_req, read_w, read_hw, read_adr, write_req, write_w, write_hw,
                      write_adr, write_data, done_v, arb_busy, req_overrun};

    mem_bus_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_read_req(i_read_req), .i_read_w(i_read_w), .i_read_hw(i_read_hw), .i_read_adr(i_read_adr),
        .d_read_req(d_read_req), .d_read_w(d_read_w), .d_read_hw(d_read_hw), .d_read_adr(d_read_adr),
        .u_read_req(u_read_req), .u_read_w(u_read_w), .u_read_adr(u_read_adr),
        .d_write_req(d_write_req), .d_write_w(d_write_w), .d_write_hw(d_write_hw),
        .d_write_adr(d_write_adr), .d_write_data(d_write_data),
        .u_write_req(u_write_req), .u_write_w(u_write_w), .u_write_adr(u_write_adr),
        .u_write_data(u_write_data),
        .read_req(read_req), .read_w(read_w), .read_hw(read_hw), .read_adr(read_adr),
        .write_req(write_req), .write_w(write_w), .write_hw(write_hw),
        .write_adr(write_adr), .write_data(write_data),
        .read_valid(read_valid), .write_finish(write_finish),
        .i_read_valid(i_read_valid), .d_read_valid(d_read_valid), .u_read_valid(u_read_valid),
        .d_write_finish(d_write_finish), .u_write_finish(u_write_finish),
        .arb_busy(arb_busy), .req_overrun(req_overrun)
`ifdef MEM_ARB_TIMEOUT_EN
        , .arb_timeout(arb_timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_reqs();
        i_read_req = 0; d_read_req = 0; u_read_req = 0; d_write_req = 0; u_write_req = 0;
    endtask

    // Drive one source's request fields for the current cycle; optionally queue the expected command.
    task automatic set_req(input int src, input logic [31:0] adr, input logic w, input logic hw,
                           input logic [31:0] data, input bit push);
        exp_t e;
        case (src)
            0: begin d_write_req = 1; d_write_adr = adr; d_write_w = w; d_write_hw = hw; d_write_data = data; end
            1: begin d_read_req = 1; d_read_adr = adr; d_read_w = w; d_read_hw = hw; end
            2: begin i_read_req = 1; i_read_adr = adr; i_read_w = w; i_read_hw = hw; end
            3: begin u_write_req = 1; u_write_adr = adr; u_write_w = w; u_write_data = data; end
            default: begin u_read_req = 1; u_read_adr = adr; u_read_w = w; end
        endcase
        e.is_wr = (src == 0) || (src == 3);
        e.src   = 3'(src);
        e.w     = w;
        e.hw    = (src >= 3) ? 1'b0 : hw;
        e.adr   = adr;
        e.data  = e.is_wr ? data : 32'h0;
        if (push) sb_q.push_back(e);
    endtask

    task automatic apply_reset();
        rst_n = 0; clr_reqs(); read_valid = 0; write_finish = 0;
        repeat (3) cyc();
        rst_n = 1;
        cyc();
        sb_q.delete();
    endtask

    // Wait for the next memory command, compare it with the queue head, then complete it.
    task automatic serve(input int lat, input int inj_src, input logic [31:0] inj_adr,
                         output int t_issue, output int t_done, output int src);
        exp_t e, o;
        int   n;
        n = 0; src = -1;
        while (!(read_req || write_req) && n < 300) begin cyc(); n++; end
        t_issue = cyc_n; t_done = cyc_n;
        checks++;
        if (!(read_req || write_req) || sb_q.size() == 0) begin
            errors++;
            $display("FAIL serve_issue: req=%b/%b queued=%0d expected a command with a queued entry",
                     read_req, write_req, sb_q.size());
            return;
        end
        e = sb_q.pop_front();
        src = int'(e.src);
        o.is_wr = write_req; o.src = e.src;
        o.w     = write_req ? write_w   : read_w;
        o.hw    = write_req ? write_hw  : read_hw;
        o.adr   = write_req ? write_adr : read_adr;
        o.data  = write_req ? write_data : 32'h0;
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL mem_cmd: got wr=%b w=%b hw=%b adr=%h data=%h, want wr=%b w=%b hw=%b adr=%h data=%h",
                     o.is_wr, o.w, o.hw, o.adr, o.data, e.is_wr, e.w, e.hw, e.adr, e.data);
        end
        cyc();
        if (e.is_wr) read_valid = 1; else write_finish = 1;
        #1;
        checks++;
        if (read_req || write_req || done_v !== 5'b0 || arb_busy !== 1'b1 ||
            (e.is_wr ? write_adr : read_adr) !== e.adr) begin
            errors++;
            $display("FAIL wait_state: req=%b/%b done=%b busy=%b adr=%h want 0/0 00000 1 %h",
                     read_req, write_req, done_v, arb_busy, e.is_wr ? write_adr : read_adr, e.adr);
        end
        cyc();
        read_valid = 0; write_finish = 0;
        repeat (lat) cyc();
        if (e.is_wr) write_finish = 1; else read_valid = 1;
        if (inj_src >= 0) set_req(inj_src, inj_adr, 1'b1, 1'b0, 32'h0, 1'b1);
        #1;
        t_done = cyc_n;
        checks++;
        if (done_v !== (5'b1 << e.src)) begin
            errors++;
            $display("FAIL completion: done=%b want %b", done_v, 5'b1 << e.src);
        end
        cyc();
        read_valid = 0; write_finish = 0; clr_reqs();
        #1;
        checks++;
        if (done_v !== 5'b0 || arb_busy !== 1'b0) begin
            errors++;
            $display("FAIL post_completion: done=%b busy=%b want 00000 0", done_v, arb_busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        #1;
        checks++;
        if (all_out !== '0) begin errors++; $display("FAIL reset_hold: outputs=%h want 0", all_out); end
        apply_reset();
        checks++;
        if (all_out !== '0) begin errors++; $display("FAIL reset_release: outputs=%h want 0", all_out); end
`ifdef MEM_ARB_TIMEOUT_EN
        checks++;
        if (arb_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", arb_timeout); end
`endif
    endtask

    task automatic test_single_read();
        int t_req, ti, td, s;
        set_req(2, 32'h0000_1000, 1'b1, 1'b0, 32'h0, 1'b1);
        t_req = cyc_n;
        cyc(); clr_reqs();
        checks++;
        if (read_req !== 1'b0) begin errors++; $display("FAIL early_read_req: got %b want 0", read_req); end
        serve(6, -1, 32'h0, ti, td, s);
        checks++;
        if (ti != t_req + 2) begin errors++; $display("FAIL issue_latency: got %0d want %0d", ti - t_req, 2); end
        checks++;
        if (td != t_req + 10) begin errors++; $display("FAIL done_cycle: got %0d want %0d", td - t_req, 10); end
    endtask

    task automatic test_simultaneous();
        int t_req, ti, td, s, prev_done;
        apply_reset();
        set_req(1, 32'h0000_0020, 1'b1, 1'b0, 32'h0, 1'b0);
        set_req(0, 32'h0000_0010, 1'b1, 1'b0, 32'h1111_1111, 1'b1);
        set_req(2, 32'h0000_0030, 1'b0, 1'b1, 32'h0, 1'b0);
        sb_q.push_back('{is_wr: 1'b0, src: 3'd1, w: 1'b1, hw: 1'b0, adr: 32'h20, data: 32'h0});
        sb_q.push_back('{is_wr: 1'b0, src: 3'd2, w: 1'b0, hw: 1'b1, adr: 32'h30, data: 32'h0});
        t_req = cyc_n;
        cyc(); clr_reqs();
        serve(2, -1, 32'h0, ti, td, s);
        checks++;
        if (ti != t_req + 2) begin errors++; $display("FAIL multi_latency: got %0d want 2", ti - t_req); end
        for (int k = 0; k < 2; k++) begin
            prev_done = td;
            serve(1, -1, 32'h0, ti, td, s);
            checks++;
            if (ti < prev_done + 2) begin
                errors++; $display("FAIL back_to_back_gap: got %0d want >= 2", ti - prev_done);
            end
        end
    endtask

    task automatic test_write();
        int ti, td, s;
        set_req(0, 32'h0000_0040, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b1);
        cyc(); clr_reqs();
        serve(3, -1, 32'h0, ti, td, s);
        set_req(3, 32'h0000_0080, 1'b1, 1'b0, 32'h1234_5678, 1'b1);
        cyc(); clr_reqs();
        serve(0, -1, 32'h0, ti, td, s);
    endtask

    task automatic test_back_to_back();
        int ti, td, s;
        apply_reset();
        set_req(1, 32'h0000_0100, 1'b1, 1'b0, 32'h0, 1'b1);
        cyc(); clr_reqs();
        serve(2, 1, 32'h0000_0200, ti, td, s);
        serve(1, -1, 32'h0, ti, td, s);
        checks++;
        if (req_overrun !== 1'b0) begin errors++; $display("FAIL set_wins_overrun: got %b want 0", req_overrun); end
    endtask

    task automatic test_overrun_stray();
        int ti, td, s;
        apply_reset();
        read_valid = 1; write_finish = 1;
        #1;
        checks++;
        if (done_v !== 5'b0 || arb_busy !== 1'b0) begin
            errors++; $display("FAIL stray_idle: done=%b busy=%b want 00000 0", done_v, arb_busy);
        end
        cyc(); read_valid = 0; write_finish = 0;
        set_req(1, 32'h0000_0A00, 1'b1, 1'b0, 32'h0, 1'b1);
        cyc(); clr_reqs();
        checks++;
        if (read_req !== 1'b0 || write_req !== 1'b0) begin
            errors++; $display("FAIL stray_issue: req=%b/%b want 0/0", read_req, write_req);
        end
        set_req(1, 32'h0000_0B00, 1'b0, 1'b1, 32'h0, 1'b0);
        cyc(); clr_reqs();
        checks++;
        if (req_overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b want 1", req_overrun); end
        serve(2, -1, 32'h0, ti, td, s);
        checks++;
        if (req_overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b want 1", req_overrun); end
    endtask

    task automatic test_fairness();
        int ti, td, s, prev;
        apply_reset();
        set_req(2, 32'h2000_0000, 1'b1, 1'b0, 32'h0, 1'b1);
        set_req(4, 32'h4000_0000, 1'b1, 1'b0, 32'h0, 1'b1);
        cyc(); clr_reqs();
        prev = 4;
        for (int k = 1; k <= 20; k++) begin
            serve(k % 3, -1, 32'h0, ti, td, s);
            checks++;
            if (s == prev || s < 0) begin
                errors++; $display("FAIL alternation: txn %0d src %0d after src %0d", k, s, prev);
            end
            prev = s;
            if (s >= 0) set_req(s, (s == 2 ? 32'h2000_0000 : 32'h4000_0000) + 32'(k), 1'b1, 1'b0, 32'h0, 1'b1);
            cyc(); clr_reqs();
        end
    endtask

    task automatic test_reset_mid();
        int   n;
        logic seen;
        apply_reset();
        set_req(2, 32'h0000_7000, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(); clr_reqs();
        n = 0;
        while (!read_req && n < 10) begin cyc(); n++; end
        cyc();
        checks++;
        if (arb_busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", arb_busy); end
        rst_n = 0;
        #1;
        read_valid = 1;
        #1;
        checks++;
        if (all_out !== '0) begin errors++; $display("FAIL reset_abandon: outputs=%h want 0", all_out); end
        cyc(); cyc();
        rst_n = 1; read_valid = 0;
        seen = 0;
        repeat (10) begin cyc(); if (read_req || write_req || arb_busy) seen = 1; end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL reset_pending_cleared: activity=%b want 0", seen); end
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n, t_issue;
        apply_reset();
        set_req(4, 32'h0000_0300, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(); clr_reqs();
        n = 0;
        while (!read_req && n < 10) begin cyc(); n++; end
        t_issue = cyc_n;
        n = 0;
        while (!u_read_valid && n < 5000) begin cyc(); n++; end
        checks++;
        if (!u_read_valid || cyc_n != t_issue + 4096) begin
            errors++; $display("FAIL timeout_pulse: valid=%b after %0d want 1 after 4096", u_read_valid, cyc_n - t_issue);
        end
        cyc();
        checks++;
        if (arb_timeout !== 1'b1 || arb_busy !== 1'b0) begin
            errors++; $display("FAIL timeout_flag: timeout=%b busy=%b want 1 0", arb_timeout, arb_busy);
        end
    endtask
`endif

    initial begin
        rst_n = 0; read_valid = 0; write_finish = 0;
        i_read_req = 0; i_read_w = 0; i_read_hw = 0; i_read_adr = '0;
        d_read_req = 0; d_read_w = 0; d_read_hw = 0; d_read_adr = '0;
        u_read_req = 0; u_read_w = 0; u_read_adr = '0;
        d_write_req = 0; d_write_w = 0; d_write_hw = 0; d_write_adr = '0; d_write_data = '0;
        u_write_req = 0; u_write_w = 0; u_write_adr = '0; u_write_data = '0;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_write();
        test_back_to_back();
        test_overrun_stray();
        test_fairness();
        test_reset_mid();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
